// File: rtl/alu_ctrl_pkg.sv
// Shared opcode/condition encodings, FSM states and decode helpers for the
// ALU control sequencer.
package alu_ctrl_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP = 4'd0;
  localparam logic [OP_W-1:0] OP_MOV = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD = 4'd2;
  localparam logic [OP_W-1:0] OP_ADC = 4'd3;
  localparam logic [OP_W-1:0] OP_SUB = 4'd4;
  localparam logic [OP_W-1:0] OP_SBC = 4'd5;
  localparam logic [OP_W-1:0] OP_AND = 4'd6;
  localparam logic [OP_W-1:0] OP_OR  = 4'd7;
  localparam logic [OP_W-1:0] OP_XOR = 4'd8;
  localparam logic [OP_W-1:0] OP_NOT = 4'd9;
  localparam logic [OP_W-1:0] OP_SHL = 4'd10;
  localparam logic [OP_W-1:0] OP_SHR = 4'd11;
  localparam logic [OP_W-1:0] OP_ROL = 4'd12;
  localparam logic [OP_W-1:0] OP_ROR = 4'd13;
  localparam logic [OP_W-1:0] OP_CMP = 4'd14;
  localparam logic [OP_W-1:0] OP_RSV = 4'd15;

  localparam logic [2:0] COND_ALWAYS = 3'd0;
  localparam logic [2:0] COND_Z      = 3'd1;
  localparam logic [2:0] COND_NZ     = 3'd2;
  localparam logic [2:0] COND_C      = 3'd3;
  localparam logic [2:0] COND_NC     = 3'd4;
  localparam logic [2:0] COND_N      = 3'd5;
  localparam logic [2:0] COND_NN     = 3'd6;
  localparam logic [2:0] COND_P      = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_EXEC  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Shifts/rotates run as repeated single-bit ALU passes.
  function automatic logic is_shift(input logic [OP_W-1:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);
  endfunction

  // NOP and the reserved code never reach EXEC.
  function automatic logic is_nop(input logic [OP_W-1:0] op);
    return (op == OP_NOP) || (op == OP_RSV);
  endfunction

  // Single-pass ops: everything but MOV updates flags.
  function automatic logic writes_flags(input logic [OP_W-1:0] op);
    return (op != OP_MOV);
  endfunction

  // Single-pass ops: CMP only sets flags, result is discarded.
  function automatic logic writes_acc(input logic [OP_W-1:0] op);
    return (op != OP_CMP);
  endfunction

  // Carry-in captured at CHECK; carry-consuming ops take the live C flag.
  function automatic logic cin_for(input logic [OP_W-1:0] op, input logic c);
    logic r;
    r = 1'b0;
    if ((op == OP_SUB) || (op == OP_CMP)) r = 1'b1;
    else if ((op == OP_ADC) || (op == OP_SBC)) r = c;
    return r;
  endfunction

endpackage

// File: rtl/alu_sequencer_cond_eval.sv
// Condition-code evaluator: checks a 3-bit condition against the C/N/P/Z flags.
module cond_eval
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       c,
  input  logic       n,
  input  logic       p,
  input  logic       z,
  output logic       pass
);

  // Pure decode of the condition table.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_ALWAYS: pass = 1'b1;
      COND_Z:      pass = z;
      COND_NZ:     pass = ~z;
      COND_C:      pass = c;
      COND_NC:     pass = ~c;
      COND_N:      pass = n;
      COND_NN:     pass = ~n;
      COND_P:      pass = p;
      default:     pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Control FSM in front of the ALU datapath: one command at a time, operand
// load, condition check, single or repeated ALU passes, completion pulse.
module alu_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int OP_WIDTH  = 4,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OP_WIDTH-1:0]  cmd_op,
  input  logic [2:0]           cmd_cond,
  input  logic [CNT_WIDTH-1:0] cmd_cnt,
  input  logic                 flag_c,
  input  logic                 flag_n,
  input  logic                 flag_p,
  input  logic                 flag_z,
  output logic                 ld_a,
  output logic                 ld_b,
  output logic [OP_WIDTH-1:0]  alu_sel,
  output logic                 alu_cin,
  output logic                 wr_acc,
  output logic                 enaf,
  output logic                 busy,
  output logic                 done,
  output logic                 skipped
);

  state_t               state, state_nxt;
  logic [OP_WIDTH-1:0]  op_q;
  logic [2:0]           cond_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 cin_q;
  logic                 skip_q;
  logic                 pass;
  logic                 accept;
  logic                 shift_op;
  logic                 zero_cnt;
  logic                 last_pass;

  assign accept    = cmd_valid & cmd_ready;
  assign shift_op  = is_shift(op_q);
  assign zero_cnt  = (cnt_q == '0);
  assign last_pass = (cnt_q == CNT_WIDTH'(1));

  cond_eval u_cond (
    .cond (cond_q),
    .c    (flag_c),
    .n    (flag_n),
    .p    (flag_p),
    .z    (flag_z),
    .pass (pass)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Command latch, CHECK-time captures and the shift repeat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      cond_q <= '0;
      cnt_q  <= '0;
      cin_q  <= 1'b0;
      skip_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= cmd_op;
        cond_q <= cmd_cond;
        cnt_q  <= cmd_cnt;
      end
      if (state == S_CHECK) begin
        // Frozen here: later flag movement must not change the outcome.
        cin_q  <= cin_for(op_q, flag_c);
        skip_q <= ~pass | (shift_op & zero_cnt);
      end
      if ((state == S_EXEC) && shift_op && !zero_cnt)
        cnt_q <= cnt_q - CNT_WIDTH'(1);
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_CHECK;
      S_CHECK: begin
        if (!pass || (shift_op && zero_cnt) || is_nop(op_q)) state_nxt = S_DONE;
        else                                                 state_nxt = S_EXEC;
      end
      S_EXEC:  if (!shift_op || last_pass) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from registered state; everything forced low during reset.
  always_comb begin
    cmd_ready = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    alu_sel   = OP_WIDTH'(OP_NOP);
    alu_cin   = 1'b0;
    wr_acc    = 1'b0;
    enaf      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    skipped   = 1'b0;
    if (!rst) begin
      busy = (state != S_IDLE);
      case (state)
        S_IDLE: cmd_ready = 1'b1;
        S_LOAD: begin
          ld_a = 1'b1;
          ld_b = 1'b1;
        end
        S_EXEC: begin
          alu_sel = op_q;
          if (shift_op) begin
            wr_acc = 1'b1;
            enaf   = last_pass;
          end else begin
            alu_cin = cin_q;
            wr_acc  = writes_acc(op_q);
            enaf    = writes_flags(op_q);
          end
        end
        S_DONE: begin
          done    = 1'b1;
          skipped = skip_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a command-timeline model checks every
// output every cycle; per-command literal expectations pin the model.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = '0;
  logic [2:0] cmd_cond = '0;
  logic [2:0] cmd_cnt = '0;
  logic       flag_c = 1'b0, flag_n = 1'b0, flag_p = 1'b0, flag_z = 1'b0;
  logic       ld_a, ld_b, alu_cin, wr_acc, enaf, busy, done, skipped;
  logic [3:0] alu_sel;

  int n_chk  = 0;
  int n_fail = 0;

  alu_sequencer #(.OP_WIDTH(4), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cond(cmd_cond), .cmd_cnt(cmd_cnt),
    .flag_c(flag_c), .flag_n(flag_n), .flag_p(flag_p), .flag_z(flag_z),
    .ld_a(ld_a), .ld_b(ld_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .wr_acc(wr_acc), .enaf(enaf), .busy(busy), .done(done), .skipped(skipped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: where we are in the current command's timeline (k=1 is LOAD).
  bit         m_act = 0;
  int         m_k = 0, m_n = 0;
  logic [3:0] m_op;
  logic [2:0] m_cond;
  int         m_cnt;
  bit         m_cin, m_skip;

  // Measurements taken from the DUT for the literal per-command checks.
  int mon_k = 0, mon_wr = 0, mon_en = 0, mon_lat = 0;
  bit mon_done = 0, mon_sk = 0, mon_cin = 0;
  int done_total = 0, acc_total = 0;

  function automatic bit cond_ok(input logic [2:0] cd);
    case (cd)
      3'd0: return 1'b1;
      3'd1: return flag_z;
      3'd2: return !flag_z;
      3'd3: return flag_c;
      3'd4: return !flag_c;
      3'd5: return flag_n;
      3'd6: return !flag_n;
      default: return flag_p;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [12:0] e, a;
    bit shf, fin;
    e = '0;
    fin = 0;
    if (rst) m_act = 0;
    else if (!m_act) begin
      e[12] = 1'b1;
      if (cmd_valid) begin
        m_act = 1; m_k = 0;
        m_op = cmd_op; m_cond = cmd_cond; m_cnt = int'(cmd_cnt);
      end
    end else begin
      shf = (m_op >= 4'd10) && (m_op <= 4'd13);
      e[2] = 1'b1;
      if (m_k == 1) begin
        e[11] = 1'b1; e[10] = 1'b1;
      end else if (m_k == 2) begin
        m_skip = !cond_ok(m_cond) || (shf && m_cnt == 0);
        if (m_skip || m_op == 4'd0 || m_op == 4'd15) m_n = 0;
        else m_n = shf ? m_cnt : 1;
        m_cin = (m_op == 4'd4 || m_op == 4'd14) ? 1'b1 :
                (m_op == 4'd3 || m_op == 4'd5) ? flag_c : 1'b0;
      end else if (m_k <= 2 + m_n) begin
        e[9:6] = m_op;
        if (shf) begin
          e[4] = 1'b1;
          e[3] = (m_k == 2 + m_n);
        end else begin
          e[5] = m_cin;
          e[4] = (m_op != 4'd14);
          e[3] = (m_op != 4'd1);
        end
      end else begin
        e[1] = 1'b1; e[0] = m_skip; fin = 1;
      end
    end
    a = {cmd_ready, ld_a, ld_b, alu_sel, alu_cin, wr_acc, enaf, busy, done, skipped};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL cycle_outputs @%0t: got %h expected %h (rdy,lda,ldb,sel,cin,wr,enaf,busy,done,skip)",
               $time, a, e);
    end
    if (m_act) m_k++;
    if (fin) m_act = 0;

    // Measurement side.
    if (!rst && cmd_valid && cmd_ready) begin
      mon_k = 0; mon_wr = 0; mon_en = 0; mon_done = 0; mon_cin = 0; acc_total++;
    end else if (!rst) begin
      mon_k++;
      if (wr_acc) mon_wr++;
      if (enaf) mon_en++;
      if (alu_sel != 4'd0 && alu_cin) mon_cin = 1;
      if (done) begin
        mon_done = 1; mon_lat = mon_k; mon_sk = skipped; done_total++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue one command from IDLE and wait (bounded) for its done pulse.
  task automatic run_cmd(input string nm, input logic [3:0] op, input logic [2:0] cd,
                         input logic [2:0] cnt, input bit hold, input bit drop_c,
                         input int e_wr, input int e_en, input int e_sk, input int e_lat);
    cmd_valid = 1'b1; cmd_op = op; cmd_cond = cd; cmd_cnt = cnt;
    step();
    if (!hold) cmd_valid = 1'b0;
    step();
    step();
    if (drop_c) flag_c = 1'b0;
    for (int i = 0; i < 20 && !mon_done; i++) step();
    chk({nm, "_done_seen"}, int'(mon_done), 1);
    chk({nm, "_wr_acc_count"}, mon_wr, e_wr);
    chk({nm, "_enaf_count"}, mon_en, e_en);
    chk({nm, "_skipped"}, int'(mon_sk), e_sk);
    chk({nm, "_latency"}, mon_lat, e_lat);
  endtask

  initial begin
    int d0, a0;
    step(); step();
    chk("reset_cmd_ready", int'(cmd_ready), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    step();
    chk("post_reset_ready", int'(cmd_ready), 1);

    run_cmd("add", 4'd2, 3'd0, 3'd0, 0, 0, 1, 1, 0, 4);
    chk("add_cin", int'(mon_cin), 0);
    chk("ready_after_done", int'(cmd_ready), 1);

    flag_c = 1'b1;
    run_cmd("adc", 4'd3, 3'd0, 3'd0, 0, 1, 1, 1, 0, 4);
    chk("adc_cin_held", int'(mon_cin), 1);

    flag_z = 1'b0;
    run_cmd("sub_z_false", 4'd4, 3'd1, 3'd0, 0, 0, 0, 0, 1, 3);
    flag_z = 1'b1;
    run_cmd("sub_z_true", 4'd4, 3'd1, 3'd0, 0, 0, 1, 1, 0, 4);
    chk("sub_cin", int'(mon_cin), 1);
    flag_z = 1'b0;

    run_cmd("shl5", 4'd10, 3'd0, 3'd5, 0, 0, 5, 1, 0, 8);
    run_cmd("shl0", 4'd10, 3'd0, 3'd0, 0, 0, 0, 0, 1, 3);
    run_cmd("cmp", 4'd14, 3'd0, 3'd0, 0, 0, 0, 1, 0, 4);
    run_cmd("mov", 4'd1, 3'd0, 3'd0, 0, 0, 1, 0, 0, 4);
    run_cmd("nop", 4'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 3);
    run_cmd("rsv", 4'd15, 3'd0, 3'd0, 0, 0, 0, 0, 0, 3);
    flag_c = 1'b1;
    run_cmd("rol3_c", 4'd12, 3'd3, 3'd3, 0, 0, 3, 1, 0, 6);
    chk("rol_cin_zero", int'(mon_cin), 0);
    flag_c = 1'b0;
    run_cmd("sbc_c0", 4'd5, 3'd4, 3'd0, 0, 0, 1, 1, 0, 4);
    chk("sbc_cin", int'(mon_cin), 0);
    flag_n = 1'b1;
    run_cmd("xor_nn_false", 4'd8, 3'd6, 3'd0, 0, 0, 0, 0, 1, 3);
    flag_n = 1'b0;

    // Back-to-back: valid stays high across ROR 7, next accepted after done.
    a0 = acc_total;
    run_cmd("ror7_hold", 4'd13, 3'd0, 3'd7, 1, 0, 7, 1, 0, 10);
    run_cmd("add_after", 4'd2, 3'd0, 3'd0, 0, 0, 1, 1, 0, 4);
    chk("b2b_accepts", acc_total - a0, 2);

    // Reset during EXEC of ROR 7: aborted, no done afterwards.
    d0 = done_total;
    cmd_valid = 1'b1; cmd_op = 4'd13; cmd_cond = 3'd0; cmd_cnt = 3'd7;
    step();
    cmd_valid = 1'b0;
    step(); step(); step();
    chk("rst_mid_in_exec", int'(wr_acc), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_wr_acc", int'(wr_acc), 0);
    step();
    chk("rst_mid_busy", int'(busy), 0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_release_ready", int'(cmd_ready), 1);
    for (int i = 0; i < 10; i++) step();
    chk("rst_no_done", done_total - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
